// File: rtl/bus_xfer_ctrl.sv
// Register-bus transfer initiator: OE-strobes a source register, captures the bus, then
// WE-strobes the destination. Optional immediate-write commands under BUS_XFER_IMM_EN.
module bus_xfer_ctrl #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned ID_W     = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ID_W-1:0]     cmd_src,
  input  logic [ID_W-1:0]     cmd_dst,
`ifdef BUS_XFER_IMM_EN
  input  logic                cmd_imm_sel,
  input  logic [DATA_W-1:0]   cmd_imm,
`endif
  input  logic [DATA_W-1:0]   bus_in,
  output logic [DATA_W-1:0]   bus_out,
  output logic [NUM_REGS-1:0] oe,
  output logic [NUM_REGS-1:0] we,
  output logic                xfer_done,
  output logic                xfer_err,
  output logic [DATA_W-1:0]   xfer_data
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StHold  = 3'd2;
  localparam logic [2:0] StWrite = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam logic [ID_W:0] NumRegsW = (ID_W+1)'(NUM_REGS);

  logic                imm_sel;
  logic [DATA_W-1:0]   imm_val;
`ifdef BUS_XFER_IMM_EN
  assign imm_sel = cmd_imm_sel;
  assign imm_val = cmd_imm;
`else
  assign imm_sel = 1'b0;
  assign imm_val = '0;
`endif

  logic [2:0]          state_q, state_d;
  logic [ID_W-1:0]     src_q, src_d;
  logic [ID_W-1:0]     dst_q, dst_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [DATA_W-1:0]   bus_out_q, bus_out_d;
  logic [NUM_REGS-1:0] oe_q, oe_d;
  logic [NUM_REGS-1:0] we_q, we_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   xfer_data_q, xfer_data_d;
  logic                src_bad, dst_bad;

  assign src_bad = ({1'b0, cmd_src} >= NumRegsW);
  assign dst_bad = ({1'b0, cmd_dst} >= NumRegsW);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // cmd_ready is high exactly when idle, so cmd_valid alone means accept here
        if (cmd_valid) begin
          src_d = cmd_src;
          dst_d = cmd_dst;
          if (imm_sel) begin
            data_d = imm_val;
            if (dst_bad) err_d = 1'b1;
            else         state_d = StWrite;
          end else if (src_bad || dst_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StFetch: state_d = StHold;
      StHold: begin
        data_d  = bus_in;
        state_d = StWrite;
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so every strobe comes straight from a flop
  always_comb begin
    oe_d = '0;
    we_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      oe_d[i] = ((state_d == StFetch) || (state_d == StHold)) && (src_d == ID_W'(i));
      we_d[i] = (state_d == StWrite) && (dst_d == ID_W'(i));
    end
    bus_out_d   = (state_d == StWrite) ? data_d : '0;
    done_d      = (state_d == StDone);
    xfer_data_d = (state_d == StDone) ? data_d : xfer_data_q;
    cmd_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      src_q       <= '0;
      dst_q       <= '0;
      data_q      <= '0;
      cmd_ready_q <= 1'b1;
      bus_out_q   <= '0;
      oe_q        <= '0;
      we_q        <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      xfer_data_q <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      data_q      <= data_d;
      cmd_ready_q <= cmd_ready_d;
      bus_out_q   <= bus_out_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      done_q      <= done_d;
      err_q       <= err_d;
      xfer_data_q <= xfer_data_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign bus_out   = bus_out_q;
  assign oe        = oe_q;
  assign we        = we_q;
  assign xfer_done = done_q;
  assign xfer_err  = err_q;
  assign xfer_data = xfer_data_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl with a 4-register bus model; a second 3-register
// instance covers ID range rejection.
module tb_bus_xfer_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_src = '0;
  logic [1:0] cmd_dst = '0;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic [3:0] oe, we;
  logic       xfer_done, xfer_err;
  logic [7:0] xfer_data;
`ifdef BUS_XFER_IMM_EN
  logic       cmd_imm_sel = 1'b0;
  logic [7:0] cmd_imm = '0;
`endif

  logic       cmd_valid3 = 1'b0;
  logic       cmd_ready3;
  logic [1:0] cmd_src3 = '0;
  logic [1:0] cmd_dst3 = '0;
  logic [7:0] bus_in3 = '0;
  logic [7:0] bus_out3;
  logic [2:0] oe3, we3;
  logic       xfer_done3, xfer_err3;
  logic [7:0] xfer_data3;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  bus_xfer_ctrl #(.DATA_W(8), .NUM_REGS(4), .ID_W(2)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
`ifdef BUS_XFER_IMM_EN
    .cmd_imm_sel (cmd_imm_sel),
    .cmd_imm     (cmd_imm),
`endif
    .bus_in    (bus_in),
    .bus_out   (bus_out),
    .oe        (oe),
    .we        (we),
    .xfer_done (xfer_done),
    .xfer_err  (xfer_err),
    .xfer_data (xfer_data)
  );

  bus_xfer_ctrl #(.DATA_W(8), .NUM_REGS(3), .ID_W(2)) dut3 (
    .CLK       (CLK),
    .RESET     (RESET),
    .cmd_valid (cmd_valid3),
    .cmd_ready (cmd_ready3),
    .cmd_src   (cmd_src3),
    .cmd_dst   (cmd_dst3),
`ifdef BUS_XFER_IMM_EN
    .cmd_imm_sel (1'b0),
    .cmd_imm     (8'h00),
`endif
    .bus_in    (bus_in3),
    .bus_out   (bus_out3),
    .oe        (oe3),
    .we        (we3),
    .xfer_done (xfer_done3),
    .xfer_err  (xfer_err3),
    .xfer_data (xfer_data3)
  );

  // Register file model: output flop loads on an OE edge, contents load on a WE edge
  logic [7:0] regs [4];
  logic [7:0] reg_out_q [4];
  logic       pre_en = 1'b0;
  logic [1:0] pre_idx = '0;
  logic [7:0] pre_val = '0;

  always @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      reg_out_q[i] <= oe[i] ? regs[i] : 8'h00;
      if (pre_en && pre_idx == 2'(i)) regs[i] <= pre_val;
      else if (we[i])                 regs[i] <= bus_out;
    end
  end

  assign bus_in = reg_out_q[0] | reg_out_q[1] | reg_out_q[2] | reg_out_q[3];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RESET) begin
      check_eq("inv_oe_onehot0", 32'($onehot0(oe)), 32'd1);
      check_eq("inv_we_onehot0", 32'($onehot0(we)), 32'd1);
      check_eq("inv_oe_we_excl", 32'((oe != 0) && (we != 0)), 32'd0);
      if (we == 4'b0) check_eq("inv_bus_out_idle", 32'(bus_out), 32'd0);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input logic [1:0] idx, input logic [7:0] val);
    pre_idx = idx;
    pre_val = val;
    pre_en  = 1'b1;
    tick();
    pre_en  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      regs[i]      = 8'h00;
      reg_out_q[i] = 8'h00;
    end
    tick();
    tick();
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_oe", 32'(oe), 32'd0);
    check_eq("rst_we", 32'(we), 32'd0);
    check_eq("rst_bus_out", 32'(bus_out), 32'd0);
    check_eq("rst_done", 32'(xfer_done), 32'd0);
    check_eq("rst_err", 32'(xfer_err), 32'd0);
    check_eq("rst_xfer_data", 32'(xfer_data), 32'd0);
    RESET = 1'b0;

    // Transfer reg1 -> reg2
    preload(2'd1, 8'hA5);
    cmd_src = 2'd1; cmd_dst = 2'd2; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check_eq("t1_c1_oe", 32'(oe), 32'b0010);
    check_eq("t1_c1_ready", 32'(cmd_ready), 32'd0);
    tick();
    check_eq("t1_c2_oe", 32'(oe), 32'b0010);
    check_eq("t1_c2_we", 32'(we), 32'd0);
    tick();
    check_eq("t1_c3_oe", 32'(oe), 32'd0);
    check_eq("t1_c3_we", 32'(we), 32'b0100);
    check_eq("t1_c3_bus_out", 32'(bus_out), 32'hA5);
    tick();
    check_eq("t1_c4_done", 32'(xfer_done), 32'd1);
    check_eq("t1_c4_data", 32'(xfer_data), 32'hA5);
    check_eq("t1_c4_we", 32'(we), 32'd0);
    tick();
    check_eq("t1_c5_ready", 32'(cmd_ready), 32'd1);
    check_eq("t1_c5_done", 32'(xfer_done), 32'd0);
    check_eq("t1_c5_data_hold", 32'(xfer_data), 32'hA5);
    check_eq("t1_reg2", 32'(regs[2]), 32'hA5);

    // Self transfer reg3 -> reg3
    preload(2'd3, 8'h3C);
    cmd_src = 2'd3; cmd_dst = 2'd3; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check_eq("t2_c1_oe", 32'(oe), 32'b1000);
    tick();
    check_eq("t2_c2_oe", 32'(oe), 32'b1000);
    tick();
    check_eq("t2_c3_we", 32'(we), 32'b1000);
    check_eq("t2_c3_bus_out", 32'(bus_out), 32'h3C);
    tick();
    check_eq("t2_c4_done", 32'(xfer_done), 32'd1);
    check_eq("t2_c4_data", 32'(xfer_data), 32'h3C);
    tick();
    check_eq("t2_reg3", 32'(regs[3]), 32'h3C);

    // Out-of-range IDs on the 3-register instance
    cmd_src3 = 2'd3; cmd_dst3 = 2'd0; cmd_valid3 = 1'b1;
    tick();
    cmd_valid3 = 1'b0;
    check_eq("t3_src_err", 32'(xfer_err3), 32'd1);
    check_eq("t3_src_ready", 32'(cmd_ready3), 32'd1);
    check_eq("t3_src_oe", 32'(oe3), 32'd0);
    check_eq("t3_src_we", 32'(we3), 32'd0);
    tick();
    check_eq("t3_err_pulse", 32'(xfer_err3), 32'd0);
    check_eq("t3_oe_after", 32'(oe3), 32'd0);
    cmd_src3 = 2'd0; cmd_dst3 = 2'd3; cmd_valid3 = 1'b1;
    tick();
    cmd_valid3 = 1'b0;
    check_eq("t3_dst_err", 32'(xfer_err3), 32'd1);
    check_eq("t3_dst_oe", 32'(oe3), 32'd0);
    tick();
    check_eq("t3_dst_we", 32'(we3), 32'd0);
    check_eq("t3_done", 32'(xfer_done3), 32'd0);

    // Busy commands are ignored; held request accepted only once idle again
    preload(2'd0, 8'h5A);
    cmd_src = 2'd0; cmd_dst = 2'd1; cmd_valid = 1'b1;
    tick();
    check_eq("t4_c1_oe", 32'(oe), 32'b0001);
    tick();
    cmd_src = 2'd3; cmd_dst = 2'd0;
    check_eq("t4_c2_oe", 32'(oe), 32'b0001);
    tick();
    check_eq("t4_c3_we", 32'(we), 32'b0010);
    check_eq("t4_c3_bus_out", 32'(bus_out), 32'h5A);
    check_eq("t4_c3_ready", 32'(cmd_ready), 32'd0);
    tick();
    check_eq("t4_c4_done", 32'(xfer_done), 32'd1);
    check_eq("t4_c4_ready", 32'(cmd_ready), 32'd0);
    tick();
    check_eq("t4_c5_ready", 32'(cmd_ready), 32'd1);
    check_eq("t4_c5_oe", 32'(oe), 32'd0);
    tick();
    cmd_valid = 1'b0;
    check_eq("t4_c6_oe", 32'(oe), 32'b1000);
    tick();
    tick();
    check_eq("t4_c8_we", 32'(we), 32'b0001);
    check_eq("t4_c8_bus_out", 32'(bus_out), 32'h3C);
    tick();
    check_eq("t4_c9_done", 32'(xfer_done), 32'd1);
    check_eq("t4_c9_data", 32'(xfer_data), 32'h3C);
    tick();
    check_eq("t4_reg1", 32'(regs[1]), 32'h5A);
    check_eq("t4_reg0", 32'(regs[0]), 32'h3C);

    // Reset during HOLD abandons the transfer
    preload(2'd2, 8'h11);
    cmd_src = 2'd1; cmd_dst = 2'd2; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    check_eq("t5_hold_oe", 32'(oe), 32'b0010);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check_eq("t5_rst_oe", 32'(oe), 32'd0);
    check_eq("t5_rst_we", 32'(we), 32'd0);
    check_eq("t5_rst_ready", 32'(cmd_ready), 32'd1);
    check_eq("t5_rst_data", 32'(xfer_data), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t5_no_we", 32'(we), 32'd0);
      check_eq("t5_no_done", 32'(xfer_done), 32'd0);
    end
    check_eq("t5_reg2", 32'(regs[2]), 32'h11);

`ifdef BUS_XFER_IMM_EN
    cmd_imm_sel = 1'b1; cmd_imm = 8'h7E; cmd_src = 2'd3; cmd_dst = 2'd0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd_imm_sel = 1'b0;
    check_eq("t6_c1_we", 32'(we), 32'b0001);
    check_eq("t6_c1_bus_out", 32'(bus_out), 32'h7E);
    check_eq("t6_c1_oe", 32'(oe), 32'd0);
    tick();
    check_eq("t6_c2_done", 32'(xfer_done), 32'd1);
    check_eq("t6_c2_data", 32'(xfer_data), 32'h7E);
    check_eq("t6_c2_oe", 32'(oe), 32'd0);
    tick();
    check_eq("t6_ready", 32'(cmd_ready), 32'd1);
    check_eq("t6_reg0", 32'(regs[0]), 32'h7E);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
